fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Parametrised program-counter and instruction-fetch stage for the RISC-V core. Replaces the free-running PC register and next-PC mux.
- Owns the PC and issues requests to instruction memory over a valid/ready handshake. Tolerates memory wait states.
- Presents fetched instructions to decode through a one-entry output register with valid/ready.
- Resolves control transfers (JAL, JALR, all six branches) from execute. A taken transfer redirects fetch and squashes stale fetches.

Parameters:
- XLEN, 32, width of PC, addresses and operands.
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (current PC).
- imem_rsp_valid  in  1  response data valid; at most one per accepted request, in order.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  decode-side instruction valid.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  XLEN  PC of inst_data.
- redir_valid  in  1  control instruction resolved this cycle.
- redir_kind  in  2  0=JAL, 1=BRANCH, 2=JALR, 3=reserved (ignored).
- redir_funct3  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; others never taken.
- redir_pc  in  XLEN  PC of the control instruction.
- redir_imm  in  XLEN  sign-extended immediate.
- redir_rs1  in  XLEN  rs1 operand.
- redir_rs2  in  XLEN  rs2 operand.
- redir_taken  out  1  combinational: transfer is taken and aligned.
- misalign_err  out  1  sticky: a taken target had bit 1 set.

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_VECTOR; FSM=S_REQ; drop=0.
  - inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0.
  - imem_req_valid is driven 1 from S_REQ in the first cycle after release.
- Target computation:
  - JAL: redir_pc+redir_imm.
  - BRANCH: redir_pc+redir_imm if the condition holds. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - JALR: (redir_rs1+redir_imm) with bit 0 cleared.
  - All sums are modulo 2^XLEN.
- Taken and alignment:
  - taken = redir_valid & (kind JAL | JALR | (BRANCH & cond)).
  - If taken and target[1]=1: misalign_err is set (stays set until reset), redir_taken=0, and there is no redirect.
  - A not-taken branch has no effect.
- FSM:
  - S_REQ: imem_req_valid=1, imem_req_addr=PC. On imem_req_ready go to S_WAIT.
  - S_WAIT: imem_req_valid=0. On imem_rsp_valid:
    - if drop=1: discard the response, clear drop, go to S_REQ.
    - else: load inst_data/inst_pc, set inst_valid=1, PC=PC+4 (wraps), go to S_HOLD.
  - S_HOLD: inst_valid=1. On inst_ready: clear inst_valid and go to S_REQ. This gives one bubble per instruction; the throughput limit is accepted.
- Redirect with redir_taken=1 (takes priority over every other same-cycle event):
  - PC=target, inst_valid cleared (squash).
  - In S_REQ without ready: stay in S_REQ; imem_req_addr changes to the target next cycle.
  - In S_REQ with ready the same cycle: the accepted request is stale; go to S_WAIT with drop=1.
  - In S_WAIT: drop=1, stay in S_WAIT. A same-cycle rsp_valid is discarded and the FSM goes to S_REQ.
  - In S_HOLD: go to S_REQ. inst_ready in the same cycle is ignored, and the instruction is not counted as consumed.
- imem_req_addr and imem_req_valid are stable while waiting for ready, except on redirect.
- Handshakes follow valid/ready rules: a transfer occurs only on a rising edge with both high.
- Reset asserted mid-transaction abandons the outstanding request. The memory model is reset by the same rst.

Test Plan:
- Reset release, RESET_VECTOR=32'h100, imem ready always, 1-cycle response -> requests at 0x100, 0x104, 0x108; inst_pc matches each address; inst_data equals the memory word.
- Backpressure: inst_ready=0 for 5 cycles at 0x104 -> inst_valid held, inst_data/inst_pc stable, no new imem request until consumed. imem_req_ready low 3 cycles -> addr stable.
- Branches: BLT rs1=32'hFFFF_FFFF, rs2=1 -> taken. BLTU with the same operands -> not taken, fetch continues sequentially. Taken BEQ redir_pc=0x200, imm=-8 -> next request at 0x1F8.
- JALR rs1=0x301, imm=4 -> target 0x304, redir_taken=1. JALR rs1=0x302, imm=0 -> misalign_err=1 (sticky), PC unchanged.
- Redirect while in S_WAIT to 0x400, response arrives 2 cycles later -> response dropped, inst_valid never asserted for it, next request at 0x400. Redirect coincident with rsp_valid -> same drop.
- Wrap: RESET_VECTOR=32'hFFFF_FFFC -> second request at 32'h0. Async reset asserted mid-S_WAIT -> all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: owns the PC, fetches over a valid/ready
// instruction-memory port, holds one instruction for decode and applies control transfers.
//
// state  | meaning
// S_REQ  | presenting a fetch request at the current PC
// S_WAIT | request accepted, waiting for the memory response
// S_HOLD | instruction registered and offered to decode
module fetch_pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redir_valid,
    input  logic [1:0]      redir_kind,
    input  logic [2:0]      redir_funct3,
    input  logic [XLEN-1:0] redir_pc,
    input  logic [XLEN-1:0] redir_imm,
    input  logic [XLEN-1:0] redir_rs1,
    input  logic [XLEN-1:0] redir_rs2,
    output logic            redir_taken,
    output logic            misalign_err
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            drop;
    logic            cond;
    logic            taken_raw;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] jalr_sum;

    assign pc_rel   = redir_pc + redir_imm;
    assign jalr_sum = redir_rs1 + redir_imm;

    always_comb begin
        cond = 1'b0;
        case (redir_funct3)
            3'b000:  cond = (redir_rs1 == redir_rs2);
            3'b001:  cond = (redir_rs1 != redir_rs2);
            3'b100:  cond = ($signed(redir_rs1) <  $signed(redir_rs2));
            3'b101:  cond = ($signed(redir_rs1) >= $signed(redir_rs2));
            3'b110:  cond = (redir_rs1 <  redir_rs2);
            3'b111:  cond = (redir_rs1 >= redir_rs2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        target    = '0;
        taken_raw = 1'b0;
        case (redir_kind)
            2'd0: begin
                target    = pc_rel;
                taken_raw = redir_valid;
            end
            2'd1: begin
                target    = pc_rel;
                taken_raw = redir_valid & cond;
            end
            2'd2: begin
                target    = {jalr_sum[XLEN-1:1], 1'b0};
                taken_raw = redir_valid;
            end
            default: begin
                target    = '0;
                taken_raw = 1'b0;
            end
        endcase
    end

    // A misaligned target is reported but never redirects fetch.
    assign redir_taken    = taken_raw & ~target[1];
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_REQ;
            pc           <= RESET_VECTOR;
            drop         <= 1'b0;
            inst_valid   <= 1'b0;
            inst_data    <= '0;
            inst_pc      <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (taken_raw & target[1])
                misalign_err <= 1'b1;

            if (redir_taken) begin
                pc         <= target;
                inst_valid <= 1'b0;
                case (state)
                    S_REQ: begin
                        if (imem_req_ready) begin
                            state <= S_WAIT;
                            drop  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            state <= S_REQ;
                            drop  <= 1'b0;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (imem_req_ready)
                            state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= S_REQ;
                            end else begin
                                inst_data  <= imem_rsp_data;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                pc         <= pc + XLEN'(4);
                                state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (inst_ready) begin
                            inst_valid <= 1'b0;
                            state      <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios then random traffic, all checked against a
// transaction-level model of fetch, hold and redirect behaviour plus a latency-controlled memory.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready, rsp_valid, inst_ready;
    logic [31:0] rsp_data;
    logic        rv;
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] r_pc, r_imm, r_rs1, r_rs2;

    logic        req_valid, inst_valid, redir_taken, misalign_err;
    logic [31:0] req_addr, inst_data, inst_pc;
    logic        w_req_valid, w_inst_valid, w_redir_taken, w_misalign_err;
    logic [31:0] w_req_addr, w_inst_data, w_inst_pc;

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redir_valid(rv), .redir_kind(kind), .redir_funct3(f3), .redir_pc(r_pc),
        .redir_imm(r_imm), .redir_rs1(r_rs1), .redir_rs2(r_rs2),
        .redir_taken(redir_taken), .misalign_err(misalign_err)
    );

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .redir_valid(rv), .redir_kind(kind), .redir_funct3(f3), .redir_pc(r_pc),
        .redir_imm(r_imm), .redir_rs1(r_rs1), .redir_rs2(r_rs2),
        .redir_taken(w_redir_taken), .misalign_err(w_misalign_err)
    );

    always #5 clk = ~clk;

    // Model: PC, whether a fetch is in flight (and stale), and the instruction offered to decode.
    logic [31:0] m_pc, m_data, m_ipc;
    bit          m_out, m_stale, m_have, m_err;
    bit          mem_busy;
    int          mem_lat, lat_cfg;
    logic [31:0] mem_addr;
    logic [31:0] acc_q[$];
    int          checks = 0, failures = 0;
    int          iv_seen;
    bit          wrap_chk;
    logic        last_taken;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_pc = 32'h100; m_out = 0; m_stale = 0; m_have = 0; m_err = 0;
        m_data = '0; m_ipc = '0; mem_busy = 0; mem_lat = 0;
    endtask

    function automatic void ref_redirect(output bit tk, output bit mis, output logic [31:0] tgt);
        bit c;
        case (f3)
            3'd0: c = (r_rs1 == r_rs2);
            3'd1: c = (r_rs1 != r_rs2);
            3'd4: c = ($signed(r_rs1) <  $signed(r_rs2));
            3'd5: c = ($signed(r_rs1) >= $signed(r_rs2));
            3'd6: c = (r_rs1 <  r_rs2);
            3'd7: c = (r_rs1 >= r_rs2);
            default: c = 0;
        endcase
        tk = 0; tgt = '0;
        if (kind == 2'd0) begin tk = rv; tgt = r_pc + r_imm; end
        else if (kind == 2'd1) begin tk = rv && c; tgt = r_pc + r_imm; end
        else if (kind == 2'd2) begin tk = rv; tgt = (r_rs1 + r_imm) & 32'hFFFF_FFFE; end
        mis = tk && tgt[1];
        tk  = tk && !tgt[1];
    endfunction

    task automatic cycle();
        bit exp_req, tk, mis, acc;
        logic [31:0] tgt;
        exp_req = !m_out && !m_have;
        chk("req_valid", req_valid, exp_req);
        if (exp_req) chk("req_addr", req_addr, m_pc);
        chk("inst_valid", inst_valid, m_have);
        if (m_have) begin
            chk("inst_data", inst_data, m_data);
            chk("inst_pc", inst_pc, m_ipc);
        end
        chk("misalign_err", misalign_err, m_err);
        if (inst_valid) iv_seen++;
        if (wrap_chk) chk("wrap_addr", w_req_addr, m_pc + 32'hFFFF_FEFC);
        rsp_valid = mem_busy && mem_lat == 0;
        rsp_data  = rsp_valid ? memw(mem_addr) : $urandom();
        #1;
        ref_redirect(tk, mis, tgt);
        last_taken = redir_taken;
        chk("redir_taken", redir_taken, tk);
        acc = exp_req && ready;
        if (wrap_chk && acc && acc_q.size() == 1) chk("wrap_second_req", w_req_addr, 32'h0);
        if (acc) acc_q.push_back(m_pc);
        if (rsp_valid) mem_busy = 0;
        else if (mem_busy) mem_lat--;
        if (acc) begin
            mem_busy = 1; mem_addr = m_pc;
            mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 2)) : lat_cfg;
        end
        if (mis) m_err = 1;
        if (tk) begin
            m_pc = tgt; m_have = 0;
            if (acc) begin m_out = 1; m_stale = 1; end
            else if (m_out) begin
                if (rsp_valid) begin m_out = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else if (acc) begin
            m_out = 1;
        end else if (m_out && rsp_valid) begin
            m_out = 0;
            if (m_stale) m_stale = 0;
            else begin m_have = 1; m_data = rsp_data; m_ipc = m_pc; m_pc = m_pc + 32'd4; end
        end else if (m_have && inst_ready) begin
            m_have = 0;
        end
        @(posedge clk);
        @(negedge clk);
        rv = 0;
    endtask

    task automatic set_redir(input logic [1:0] k, input logic [2:0] f, input logic [31:0] p,
                             input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        rv = 1; kind = k; f3 = f; r_pc = p; r_imm = i; r_rs1 = a; r_rs2 = b;
    endtask

    task automatic expect_next_req(input string tag, input logic [31:0] addr);
        int n;
        n = acc_q.size();
        for (int i = 0; i < 30 && acc_q.size() == n; i++) cycle();
        chk({tag, "_seen"}, 32'(acc_q.size() > n), 32'd1);
        if (acc_q.size() > n) chk(tag, acc_q[n], addr);
    endtask

    initial begin
        int n0;
        logic [31:0] hold_addr;
        rst = 1; ready = 1; inst_ready = 1; rsp_valid = 0; rsp_data = '0;
        rv = 0; kind = 0; f3 = 0; r_pc = 0; r_imm = 0; r_rs1 = 0; r_rs2 = 0;
        lat_cfg = 0; wrap_chk = 0; iv_seen = 0;
        model_reset();
        #1 rst = 0;
        #2;
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_addr", req_addr, 32'h100);
        chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst = 1;

        wrap_chk = 1;
        for (int i = 0; i < 14; i++) cycle();
        wrap_chk = 0;
        chk("seq_req0", acc_q[0], 32'h100);
        chk("seq_req1", acc_q[1], 32'h104);
        chk("seq_req2", acc_q[2], 32'h108);

        // Decode backpressure while an instruction is held.
        inst_ready = 0;
        for (int i = 0; i < 20 && !m_have; i++) cycle();
        n0 = acc_q.size();
        hold_addr = inst_pc;
        for (int i = 0; i < 5; i++) cycle();
        chk("bp_no_req", acc_q.size(), n0);
        chk("bp_pc_stable", inst_pc, hold_addr);
        inst_ready = 1;

        // Memory not ready for three cycles.
        for (int i = 0; i < 20 && (m_out || m_have); i++) cycle();
        ready = 0;
        hold_addr = req_addr;
        for (int i = 0; i < 3; i++) cycle();
        chk("rdy_addr_stable", req_addr, hold_addr);
        ready = 1;

        set_redir(2'd1, 3'b100, 32'h80, 32'h40, 32'hFFFF_FFFF, 32'h1); cycle();
        chk("blt_taken", last_taken, 1);
        expect_next_req("blt_target", 32'hC0);
        set_redir(2'd1, 3'b110, 32'h80, 32'h40, 32'hFFFF_FFFF, 32'h1); cycle();
        chk("bltu_not_taken", last_taken, 0);
        set_redir(2'd1, 3'b000, 32'h200, 32'hFFFF_FFF8, 32'h5, 32'h5); cycle();
        expect_next_req("beq_target", 32'h1F8);
        set_redir(2'd2, 3'b000, 32'h0, 32'h4, 32'h301, 32'h0); cycle();
        chk("jalr_taken", last_taken, 1);
        expect_next_req("jalr_target", 32'h304);
        set_redir(2'd2, 3'b000, 32'h0, 32'h0, 32'h302, 32'h0); cycle();
        chk("jalr_mis_taken", last_taken, 0);
        chk("misalign_set", misalign_err, 1);

        // Redirect while waiting, response two cycles later.
        lat_cfg = 2;
        for (int i = 0; i < 30 && !(m_out && !m_stale && mem_lat == 2); i++) cycle();
        set_redir(2'd0, 3'b000, 32'h400, 32'h0, 32'h0, 32'h0);
        iv_seen = 0;
        cycle();
        expect_next_req("wait_redir", 32'h400);
        chk("wait_drop_no_inst", iv_seen, 0);

        // Redirect in the same cycle as the response.
        lat_cfg = 1;
        for (int i = 0; i < 30 && !(m_out && !m_stale && mem_busy && mem_lat == 0); i++) cycle();
        set_redir(2'd0, 3'b000, 32'h500, 32'h0, 32'h0, 32'h0);
        iv_seen = 0;
        cycle();
        expect_next_req("coinc_redir", 32'h500);
        chk("coinc_drop_no_inst", iv_seen, 0);

        // Asynchronous reset in the middle of a wait.
        lat_cfg = 3;
        for (int i = 0; i < 30 && !(m_out && mem_lat > 0); i++) cycle();
        #2 rst = 0;
        #1;
        chk("arst_req_valid", req_valid, 1);
        chk("arst_addr", req_addr, 32'h100);
        chk("arst_inst_valid", inst_valid, 0);
        chk("arst_misalign", misalign_err, 0);
        model_reset();
        @(negedge clk);
        rst = 1;

        lat_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            ready      = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) begin
                rv    = 1;
                kind  = 2'($urandom_range(0, 3));
                f3    = 3'($urandom_range(0, 7));
                r_pc  = $urandom() & 32'hFFFF_FFFC;
                r_imm = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFE)
                                                    : 32'($urandom_range(0, 255)) * 4 - 32'd512;
                r_rs1 = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
                r_rs2 = ($urandom_range(0, 1) == 0) ? r_rs1 : $urandom();
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
